// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and DataMemory bus of the load/store unit
//   master: CPU-side requester + DataMemory (drives req/op/addr/wdata and dmem_rdata)
//   slave : load_store_unit (drives busy/done/err/rdata and the dmem_* access signals)
interface load_store_unit_if;
    logic        lsu_req;
    logic [3:0]  lsu_op;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        dmem_we;
    logic        dmem_sbyte;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    modport master (
        output lsu_req, lsu_op, lsu_addr, lsu_wdata, dmem_rdata,
        input  lsu_busy, lsu_done, lsu_err, lsu_rdata, dmem_we, dmem_sbyte, dmem_addr, dmem_wdata
    );
    modport slave (
        input  lsu_req, lsu_op, lsu_addr, lsu_wdata, dmem_rdata,
        output lsu_busy, lsu_done, lsu_err, lsu_rdata, dmem_we, dmem_sbyte, dmem_addr, dmem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store sequencer between the CPU MEM phase and DataMemory
//   clk, rst (async, active-high), lsu (load_store_unit_if.slave):
//   lsu_req/op/addr/wdata in, lsu_busy/done/err/rdata out,
//   dmem_we/sbyte/addr/wdata out, dmem_rdata in.
//   READ_WAIT: cycles the word address is held before read data is captured.
//   Define LSU_ERR_EN to enable alignment/illegal-op checking; otherwise
//   addresses are force-aligned and illegal codes fall back to word access.
module load_store_unit #(
    parameter int READ_WAIT = 1
) (
    input logic clk,
    input logic rst,
    load_store_unit_if.slave lsu
);
    localparam int CW = READ_WAIT > 1 ? $clog2(READ_WAIT) : 1;
    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;
    state_t      state, state_nx;
    logic [3:0]  op_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [CW-1:0] cnt;
    logic        legal_in, bad_in, rd_last, is_sb, is_sh;
    logic [2:0]  sz_in;
    logic [31:0] addr_in, ext, merged;
    logic [7:0]  b_sel;
    logic [15:0] h_sel;
    always_comb begin
        legal_in = lsu.lsu_op[3] ? (lsu.lsu_op[2:0] <= 3'b010)
                                 : (lsu.lsu_op[2:0] != 3'b011 && lsu.lsu_op[2:1] != 2'b11);
`ifdef LSU_ERR_EN
        sz_in   = lsu.lsu_op[2:0];
        addr_in = lsu.lsu_addr;
        bad_in  = !legal_in || (sz_in[1:0] == 2'b01 && addr_in[0])
                            || (sz_in == 3'b010 && addr_in[1:0] != 2'b00);
`else
        // illegal codes degrade to word access; sub-word offsets that would misalign are dropped
        sz_in   = legal_in ? lsu.lsu_op[2:0] : 3'b010;
        addr_in = {lsu.lsu_addr[31:2],
                   sz_in == 3'b010 ? 2'b00 : {lsu.lsu_addr[1], lsu.lsu_addr[0] & (sz_in[1:0] != 2'b01)}};
        bad_in  = 1'b0;
`endif
    end
    assign rd_last = cnt == CW'(READ_WAIT - 1);
    assign is_sb   = op_q[2:0] == 3'b000;
    assign is_sh   = op_q[2:0] == 3'b001;
    assign b_sel   = 8'(lsu.dmem_rdata >> {addr_q[1:0], 3'b000});
    assign h_sel   = addr_q[1] ? lsu.dmem_rdata[31:16] : lsu.dmem_rdata[15:0];
    // op_q[2] marks the zero-extending BU/HU variants
    assign ext     = op_q[1:0] == 2'b00 ? {{24{b_sel[7] & !op_q[2]}}, b_sel}
                   : op_q[1:0] == 2'b01 ? {{16{h_sel[15] & !op_q[2]}}, h_sel}
                   : lsu.dmem_rdata;
    assign merged  = addr_q[1] ? {wdata_q[15:0], lsu.dmem_rdata[15:0]}
                               : {lsu.dmem_rdata[31:16], wdata_q[15:0]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // SH reuses wdata_q to hold the merged word for the write cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && lsu.lsu_req) begin
                op_q    <= {lsu.lsu_op[3], sz_in};
                addr_q  <= addr_in;
                wdata_q <= lsu.lsu_wdata;
                cnt     <= '0;
            end
            if (state == RD) begin
                cnt <= cnt + 1'b1;
                if (rd_last && op_q[3])
                    wdata_q <= merged;
                if (rd_last && !op_q[3])
                    rdata_q <= ext;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (lsu.lsu_req)
                         state_nx = bad_in ? ERR : (!lsu.lsu_op[3] || sz_in == 3'b001) ? RD : WR;
            RD:      if (rd_last)
                         state_nx = op_q[3] ? WR : DONE;
            WR:      state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        lsu.lsu_busy   = state != IDLE;
        lsu.lsu_done   = state == DONE || state == ERR;
`ifdef LSU_ERR_EN
        lsu.lsu_err    = state == ERR;
`else
        lsu.lsu_err    = 1'b0;
`endif
        lsu.dmem_we    = state == WR;
        lsu.dmem_sbyte = state == WR && is_sb;
        lsu.dmem_addr  = (state == RD || (state == WR && is_sh)) ? {addr_q[31:2], 2'b00}
                       : state == WR ? addr_q : '0;
        lsu.dmem_wdata = state != WR ? '0 : is_sb ? {24'b0, wdata_q[7:0]} : wdata_q;
    end
    assign lsu.lsu_rdata = rdata_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle memory-access controller sitting between the CPU control FSM (MEM phase) and DataMemory. It accepts one load/store request at a time and sequences DataMemory accesses, performing halfword stores by read-modify-write. It extracts and sign- or zero-extends sub-word load data and checks alignment. Little-endian: byte k of a word is bits [8k+7:8k].

Parameters:
READ_WAIT, 1, number of cycles the word address is held on o_DMem_addr before i_DMem_rData is captured (>=1).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
i_LSU_req  input  1  request strobe; sampled only in IDLE
i_LSU_op  input  4  [3]=store; [2:0]: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
i_LSU_addr  input  32  byte address
i_LSU_wData  input  32  store data, right-aligned
o_LSU_busy  output  1  high in every state except IDLE
o_LSU_done  output  1  one-cycle completion pulse
o_LSU_err  output  1  one-cycle pulse with done: misaligned or illegal op
o_LSU_rData  output  32  extended load result, held until next load completes
o_DMem_we  output  1  DataMemory write enable
o_DMem_sByte  output  1  DataMemory byte-store select
o_DMem_addr  output  32  DataMemory address
o_DMem_wData  output  32  DataMemory write data
i_DMem_rData  input  32  DataMemory read data: aligned word at addr[31:2]

Behaviour:
- Reset: state IDLE; busy, done, err, o_DMem_we, o_DMem_sByte = 0; o_LSU_rData, o_DMem_addr, o_DMem_wData = 0. Reset takes effect immediately and aborts any access in flight. An aborted WR performs no write.
- IDLE: on i_LSU_req, latch op, addr and wData. Then go to:
  - ERR if the op is illegal (store with [2:0] not in {000,001,010}; load with [2:0] in {011,110,111}) or misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0).
  - RD for any load or SH.
  - WR for SB/SW.
- Requests while busy are ignored (not queued).
- RD: o_DMem_addr={addr[31:2],2'b00}, we=0, sByte=0 for READ_WAIT cycles. Capture i_DMem_rData at the edge ending the last cycle.
  - Load: go to DONE; the extracted result loads o_LSU_rData at that same edge.
  - SH: go to WR with merged word = captured word with halfword addr[1] replaced by wData[15:0].
- Load extraction: B/BU select byte addr[1:0]; H/HU select halfword addr[1]. B/H sign-extend; BU/HU zero-extend. W is passed through.
- WR: o_DMem_we=1 for exactly one cycle, then DONE.
  - SW: addr as latched, sByte=0, wData as latched.
  - SB: addr unaligned as latched, sByte=1, wData={24'b0,wData[7:0]}.
  - SH: word-aligned addr, sByte=0, merged word.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1 and err=1 for one cycle, then IDLE. No DataMemory access; o_LSU_rData unchanged.
- In all states other than WR, o_DMem_we=0.
- Latency, with request accepted at edge N (IDLE→next state): done is high in cycle N+1+k.
  - SW/SB: k=1.
  - Loads: k=READ_WAIT.
  - SH: k=READ_WAIT+1.
  - ERR: k=0.
- Back-to-back: a new request may be accepted in the IDLE cycle after DONE. Throughput is at most one access per k+2 cycles.

Optional Feature:
LSU_ERR_EN:
- Defined: alignment and illegal-op checking as above, with o_LSU_err driven.
- Undefined: no checks and o_LSU_err tied 0.
  - Addresses are force-aligned: H/HU/SH clear addr[0]; W/SW clear addr[1:0].
  - Illegal store codes act as SW; illegal load codes act as W.

Test Plan:
1. SW addr 0x4 data 0x8765_4321 → one WR cycle with we=1, sByte=0, addr 0x4, wData 0x87654321; done at N+2. Then LW 0x4 → rData 0x87654321, done at N+2.
2. LB 0x7 → rData 0xFFFF_FF87. LBU 0x7 → 0x0000_0087. LH 0x6 → 0xFFFF_8765. LHU 0x4 → 0x0000_4321.
3. SB 0x8 data 0x1234_56A5 onto zero word → we=1, sByte=1, addr 0x8, wData 0x0000_00A5. Then LW 0x8 → 0x0000_00A5.
4. SH 0x6 data 0x0000_BEEF onto word 0x87654321 → RD cycle (we=0, addr 0x4), then WR with wData 0xBEEF_4321, sByte=0; done at N+3. Then LH 0x6 → 0xFFFF_BEEF.
5. LW 0x5 → with LSU_ERR_EN: err=done=1 at N+1, we never asserted, rData unchanged. Without: reads addr 0x4, no err.
6. rst asserted mid-cycle during WR of SW 0x4 data 0xDEAD_BEEF → we drops immediately, busy=0. A later LW 0x4 does not return 0xDEADBEEF. A req asserted while busy is ignored: no second done.
